// File: rtl/chess_pkg.sv
// chess_pkg: board square, piece and direction types shared by the king move evaluator and controller.
package chess_pkg;

    localparam int unsigned COORD_W = 3;
    localparam int unsigned SQ_W    = 5;

    localparam logic [2:0] PAWN   = 3'b001;
    localparam logic [2:0] KNIGHT = 3'b010;
    localparam logic [2:0] BISHOP = 3'b011;
    localparam logic [2:0] ROOK   = 3'b100;
    localparam logic [2:0] QUEEN  = 3'b101;
    localparam logic [2:0] KING   = 3'b110;

    typedef struct packed {
        logic [2:0] ptype;
        logic       color;
        logic       occupied;
    } square_t;

    typedef enum logic [2:0] {
        DIR_UP_LEFT    = 3'd0,
        DIR_LEFT       = 3'd1,
        DIR_DOWN_LEFT  = 3'd2,
        DIR_DOWN       = 3'd3,
        DIR_DOWN_RIGHT = 3'd4,
        DIR_RIGHT      = 3'd5,
        DIR_UP_RIGHT   = 3'd6,
        DIR_UP         = 3'd7
    } dir_e;

    typedef enum logic [2:0] {
        KMC_IDLE   = 3'd0,
        KMC_CHECK  = 3'd1,
        KMC_WR_DST = 3'd2,
        KMC_WR_SRC = 3'd3,
        KMC_RESP   = 3'd4
    } kmc_state_e;

endpackage

// File: rtl/king_move_ctrl_if.sv
// king_move_ctrl_if: request/response, evaluator and board-store signals of the king move controller.
interface king_move_ctrl_if;
    import chess_pkg::*;

    logic               req_valid;
    logic [2:0]         req_dir;
    logic               req_color;
    logic               req_ready;
    logic [COORD_W-1:0] king_row;
    logic [COORD_W-1:0] king_col;
    logic               king_color;
    logic [7:0]         king_allow;
    logic [COORD_W-1:0] rd_row;
    logic [COORD_W-1:0] rd_col;
    square_t            rd_data;
    logic               wr_en;
    logic [COORD_W-1:0] wr_row;
    logic [COORD_W-1:0] wr_col;
    square_t            wr_data;
    logic               rsp_valid;
    logic               rsp_ok;
    square_t            captured;
    logic               game_over;

    modport master (
        output req_valid, req_dir, req_color, king_allow, rd_data,
        input  req_ready, king_row, king_col, king_color, rd_row, rd_col,
               wr_en, wr_row, wr_col, wr_data, rsp_valid, rsp_ok, captured, game_over
    );

    modport slave (
        input  req_valid, req_dir, req_color, king_allow, rd_data,
        output req_ready, king_row, king_col, king_color, rd_row, rd_col,
               wr_en, wr_row, wr_col, wr_data, rsp_valid, rsp_ok, captured, game_over
    );

endinterface

// File: rtl/king_step.sv
// king_step: one-square king step with bounds check; off-board results are flagged, never wrapped.
module king_step
    import chess_pkg::*;
(
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    input  dir_e               i_dir,
    output logic [COORD_W-1:0] o_row_c,
    output logic [COORD_W-1:0] o_col_c,
    output logic               o_in_bounds_c
);

    logic signed [3:0] w_dr;
    logic signed [3:0] w_dc;
    logic signed [3:0] w_row;
    logic signed [3:0] w_col;

    always_comb begin
        w_dr = 4'sd0;
        w_dc = 4'sd0;
        unique case (i_dir)
            DIR_UP:         begin w_dr = -4'sd1; w_dc =  4'sd0; end
            DIR_UP_RIGHT:   begin w_dr = -4'sd1; w_dc =  4'sd1; end
            DIR_RIGHT:      begin w_dr =  4'sd0; w_dc =  4'sd1; end
            DIR_DOWN_RIGHT: begin w_dr =  4'sd1; w_dc =  4'sd1; end
            DIR_DOWN:       begin w_dr =  4'sd1; w_dc =  4'sd0; end
            DIR_DOWN_LEFT:  begin w_dr =  4'sd1; w_dc = -4'sd1; end
            DIR_LEFT:       begin w_dr =  4'sd0; w_dc = -4'sd1; end
            DIR_UP_LEFT:    begin w_dr = -4'sd1; w_dc = -4'sd1; end
        endcase
    end

    // 7+1 lands on -8 and 0-1 on -1 in 4-bit signed, so bit 3 flags both edges
    assign w_row         = $signed({1'b0, i_row}) + w_dr;
    assign w_col         = $signed({1'b0, i_col}) + w_dc;
    assign o_row_c       = w_row[2:0];
    assign o_col_c       = w_col[2:0];
    assign o_in_bounds_c = ~w_row[3] & ~w_col[3];

endmodule

// File: rtl/king_move_ctrl.sv
// king_move_ctrl: owns both king squares, checks one-step moves against the evaluator and commits them.
// Build option KING_MOVE_TURN_EN: an internal turn register supplies the mover colour instead of req_color.
module king_move_ctrl
    import chess_pkg::*;
#(
    parameter int unsigned WHITE_ROW = 7,
    parameter int unsigned BLACK_ROW = 0,
    parameter int unsigned KING_COL  = 4
) (
    input  logic            clk,
    input  logic            reset,
    king_move_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = KMC_IDLE;
    localparam logic [2:0] S_CHECK  = KMC_CHECK;
    localparam logic [2:0] S_WR_DST = KMC_WR_DST;
    localparam logic [2:0] S_WR_SRC = KMC_WR_SRC;
    localparam logic [2:0] S_RESP   = KMC_RESP;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    dir_e               r_dir;
    logic               r_color;
    logic [COORD_W-1:0] r_wk_row, r_wk_col, r_bk_row, r_bk_col;
    logic               r_ready, r_wr_en, r_rsp_valid, r_ok, r_game_over;
    logic [COORD_W-1:0] r_wr_row, r_wr_col;
    square_t            r_wr_data, r_captured;

    logic [COORD_W-1:0] w_king_row, w_king_col, w_dst_row, w_dst_col;
    logic               w_in_bounds, w_accept, w_legal, w_hold, w_king_taken;

    assign w_king_row   = r_color ? r_bk_row : r_wk_row;
    assign w_king_col   = r_color ? r_bk_col : r_wk_col;
    assign w_accept     = bus.req_valid & r_ready;
    assign w_legal      = w_in_bounds & bus.king_allow[r_dir] & ~r_game_over;
    assign w_hold       = (r_state == S_CHECK) | (r_state == S_WR_DST) | (r_state == S_WR_SRC);
    assign w_king_taken = r_ok & r_captured.occupied & (r_captured.ptype == KING)
                        & (r_captured.color != r_color);

    king_step u_step (
        .i_row         (w_king_row),
        .i_col         (w_king_col),
        .i_dir         (r_dir),
        .o_row_c       (w_dst_row),
        .o_col_c       (w_dst_col),
        .o_in_bounds_c (w_in_bounds)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_CHECK;
            S_CHECK:  w_state_nxt = w_legal ? S_WR_DST : S_RESP;
            S_WR_DST: w_state_nxt = S_WR_SRC;
            S_WR_SRC: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, king squares and registered outputs (decoded from the next state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dir       <= DIR_UP_LEFT;
            r_color     <= 1'b0;
            r_wk_row    <= COORD_W'(WHITE_ROW);
            r_wk_col    <= COORD_W'(KING_COL);
            r_bk_row    <= COORD_W'(BLACK_ROW);
            r_bk_col    <= COORD_W'(KING_COL);
            r_ready     <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_ok        <= 1'b0;
            r_captured  <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_ready     <= (w_state_nxt == S_IDLE);
            r_wr_en     <= (w_state_nxt == S_WR_DST) || (w_state_nxt == S_WR_SRC);
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_wr_row    <= '0;
            r_wr_col    <= '0;
            r_wr_data   <= '0;
            if (w_state_nxt == S_WR_DST) begin
                r_wr_row  <= w_dst_row;
                r_wr_col  <= w_dst_col;
                r_wr_data <= square_t'{ptype: KING, color: r_color, occupied: 1'b1};
            end else if (w_state_nxt == S_WR_SRC) begin
                r_wr_row <= w_king_row;
                r_wr_col <= w_king_col;
            end

            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_dir      <= dir_e'(bus.req_dir);
                    r_ok       <= 1'b0;
                    r_captured <= '0;
`ifndef KING_MOVE_TURN_EN
                    r_color    <= bus.req_color;
`endif
                end
                S_CHECK: if (w_legal) begin
                    r_ok       <= 1'b1;
                    r_captured <= bus.rd_data;
                end
                S_WR_SRC: begin
                    if (r_color) begin
                        r_bk_row <= w_dst_row;
                        r_bk_col <= w_dst_col;
                    end else begin
                        r_wk_row <= w_dst_row;
                        r_wk_col <= w_dst_col;
                    end
                end
                S_RESP: begin
                    if (w_king_taken) r_game_over <= 1'b1;
`ifdef KING_MOVE_TURN_EN
                    if (r_ok) r_color <= ~r_color;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef KING_MOVE_TURN_EN
    logic w_unused_req_color;
    assign w_unused_req_color = bus.req_color;
`endif

    assign bus.req_ready  = r_ready;
    assign bus.king_row   = w_king_row;
    assign bus.king_col   = w_king_col;
    assign bus.king_color = r_color;
    assign bus.rd_row     = w_hold ? w_dst_row : '0;
    assign bus.rd_col     = w_hold ? w_dst_col : '0;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_row     = r_wr_row;
    assign bus.wr_col     = r_wr_col;
    assign bus.wr_data    = r_wr_data;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_ok     = r_ok;
    assign bus.captured   = r_captured;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_king_move_ctrl.sv
// tb_king_move_ctrl: table-driven moves with a write/response scoreboard, plus reset and game-over sequences.
module tb_king_move_ctrl;
    import chess_pkg::*;

    typedef struct {
        logic [2:0] dir;
        logic       color;
        logic [7:0] allow;
        logic       poke;
        logic [2:0] prow;
        logic [2:0] pcol;
        logic [4:0] pdata;
        logic       exp_ok;
        logic [4:0] exp_cap;
        logic [2:0] exp_row;
        logic [2:0] exp_col;
    } vec_t;

    typedef struct { int cyc; logic ok; logic [4:0] cap; } rsp_exp_t;
    typedef struct { int cyc; logic [2:0] row; logic [2:0] col; logic [4:0] data; } wr_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         sb_en = 1'b0;
    logic [4:0] board [8][8];
    rsp_exp_t   rsp_q[$];
    wr_exp_t    wr_q[$];
    rsp_exp_t   m_r;
    wr_exp_t    m_w;
    vec_t       vecs[12];
    logic [2:0] wk_row, wk_col, bk_row, bk_col;

    king_move_ctrl_if bus();

    king_move_ctrl #(.WHITE_ROW(7), .BLACK_ROW(0), .KING_COL(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rd_data = board[bus.rd_row][bus.rd_col];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Board store model: writes land when the controller strobes them
    always @(negedge clk) begin
        if (sb_en && bus.wr_en) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'(bus.wr_en), 32'(0));
            end else begin
                m_w = wr_q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(m_w.cyc));
                chk("wr_row", 32'(bus.wr_row), 32'(m_w.row));
                chk("wr_col", 32'(bus.wr_col), 32'(m_w.col));
                chk("wr_data", 32'(bus.wr_data), 32'(m_w.data));
            end
            board[bus.wr_row][bus.wr_col] = bus.wr_data;
        end
        if (sb_en && bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
            end else begin
                m_r = rsp_q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(m_r.cyc));
                chk("rsp_ok", 32'(bus.rsp_ok), 32'(m_r.ok));
                chk("rsp_captured", 32'(bus.captured), 32'(m_r.cap));
            end
        end
    end

    task automatic board_init();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                board[r][c] = 5'b0;
        board[7][4] = 5'b11001;
        board[0][4] = 5'b11011;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        board_init();
        wk_row = 3'd7; wk_col = 3'd4;
        bk_row = 3'd0; bk_col = 3'd4;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [2:0] dir, input logic color, input logic [7:0] allow,
                        input logic ok, input logic [4:0] cap,
                        input logic [2:0] drow, input logic [2:0] dcol,
                        input logic [2:0] srow, input logic [2:0] scol);
        rsp_exp_t r;
        wr_exp_t  w;
        int       n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_dir    = dir;
        bus.req_color  = color;
        bus.king_allow = allow;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'(1));
        r.cyc = cyc + (ok ? 4 : 2);
        r.ok  = ok;
        r.cap = cap;
        rsp_q.push_back(r);
        if (ok) begin
            w.cyc = cyc + 2; w.row = drow; w.col = dcol; w.data = {3'b110, color, 1'b1};
            wr_q.push_back(w);
            w.cyc = cyc + 3; w.row = srow; w.col = scol; w.data = 5'b0;
            wr_q.push_back(w);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, 32'(rsp_q.size() + wr_q.size()), 32'(0));
        rsp_q.delete();
        wr_q.delete();
        @(negedge clk);
    endtask

    initial begin
        vec_t       v;
        logic [2:0] sr, sc;
        logic       exp_c;
        bit         seen;

        vecs[0]  = '{3'd7, 1'b0, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b1, 5'b0,     3'd6, 3'd4};
        vecs[1]  = '{3'd3, 1'b1, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b1, 5'b0,     3'd1, 3'd4};
        vecs[2]  = '{3'd5, 1'b0, 8'hDF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b0, 5'b0,     3'd6, 3'd4};
        vecs[3]  = '{3'd5, 1'b0, 8'hFF, 1'b1, 3'd6, 3'd5, 5'b00111, 1'b1, 5'b00111, 3'd6, 3'd5};
        vecs[4]  = '{3'd1, 1'b1, 8'hFF, 1'b1, 3'd1, 3'd3, 5'b10001, 1'b1, 5'b10001, 3'd1, 3'd3};
        vecs[5]  = '{3'd2, 1'b0, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b1, 5'b0,     3'd7, 3'd4};
        vecs[6]  = '{3'd7, 1'b1, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b1, 5'b0,     3'd0, 3'd3};
        vecs[7]  = '{3'd4, 1'b0, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b0, 5'b0,     3'd7, 3'd4};
        vecs[8]  = '{3'd1, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 5'b0,     1'b0, 5'b0,     3'd7, 3'd4};
        vecs[9]  = '{3'd7, 1'b0, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b1, 5'b0,     3'd6, 3'd4};
        vecs[10] = '{3'd7, 1'b1, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b0, 5'b0,     3'd0, 3'd3};
        vecs[11] = '{3'd0, 1'b1, 8'hFF, 1'b0, 3'd0, 3'd0, 5'b0,     1'b0, 5'b0,     3'd0, 3'd3};

        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_dir    = 3'd0;
        bus.req_color  = 1'b0;
        bus.king_allow = 8'hFF;
        board_init();
        wk_row = 3'd7; wk_col = 3'd4;
        bk_row = 3'd0; bk_col = 3'd4;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
        chk("rst_king_square", 32'({bus.king_color, bus.king_row, bus.king_col}), 32'({1'b0, 3'd7, 3'd4}));
        chk("rst_wr", 32'({bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data}), 32'(0));
        chk("rst_rd", 32'({bus.rd_row, bus.rd_col}), 32'(0));
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_ok, bus.captured, bus.game_over}), 32'(0));
        reset = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);

        // White king on its home row cannot step down off the board
        send(3'd3, 1'b0, 8'hFF, 1'b0, 5'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_done("oob_down");
        chk("oob_down_king_row", 32'(bus.king_row), 32'(7));

        for (int i = 0; i < 12; i++) begin
            v  = vecs[i];
            sr = v.color ? bk_row : wk_row;
            sc = v.color ? bk_col : wk_col;
            if (v.poke) board[v.prow][v.pcol] = v.pdata;
            send(v.dir, v.color, v.allow, v.exp_ok, v.exp_cap, v.exp_row, v.exp_col, sr, sc);
            wait_done($sformatf("vec%0d", i));
            if (v.color) begin
                bk_row = v.exp_row; bk_col = v.exp_col;
            end else begin
                wk_row = v.exp_row; wk_col = v.exp_col;
            end
`ifdef KING_MOVE_TURN_EN
            exp_c = v.exp_ok ? ~v.color : v.color;
            chk($sformatf("vec%0d_turn", i), 32'(bus.king_color), 32'(exp_c));
`else
            exp_c = v.color;
            chk($sformatf("vec%0d_king", i), 32'({bus.king_color, bus.king_row, bus.king_col}),
                32'({exp_c, v.exp_row, v.exp_col}));
`endif
            chk($sformatf("vec%0d_game_over", i), 32'(bus.game_over), 32'(0));
        end

        // Reset while the destination write is on the bus
        do_reset();
        sb_en = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_dir    = 3'd7;
        bus.req_color  = 1'b0;
        bus.king_allow = 8'hFF;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = bus.wr_en;
        end
        chk("midop_wr_dst_seen", 32'(seen), 32'(1));
        reset = 1'b1;
        #1;
        chk("midop_wr_en", 32'(bus.wr_en), 32'(0));
        chk("midop_ready", 32'(bus.req_ready), 32'(1));
        chk("midop_king_square", 32'({bus.king_color, bus.king_row, bus.king_col}), 32'({1'b0, 3'd7, 3'd4}));
        chk("midop_rsp", 32'({bus.rsp_valid, bus.rsp_ok, bus.captured}), 32'(0));
        board_init();
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("midop_no_rsp", 32'(seen), 32'(0));
        sb_en = 1'b1;

        // Capturing the black king ends the game; further moves are refused
        board[6][4] = 5'b11011;
        send(3'd7, 1'b0, 8'hFF, 1'b1, 5'b11011, 3'd6, 3'd4, 3'd7, 3'd4);
        wait_done("king_capture");
        chk("king_capture_game_over", 32'(bus.game_over), 32'(1));
        send(3'd3, 1'b1, 8'hFF, 1'b0, 5'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        wait_done("after_game_over");
        chk("after_game_over_sticky", 32'(bus.game_over), 32'(1));
        chk("after_game_over_black_king", 32'(bus.king_row), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
